// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 16x-oversampling UART receiver and transmitter.
//   - rx_state_e : receiver state encoding (idle / start / data / stop)
//   - OsRate, vote indices : oversampling constants
//   - calc_div() : clocks per oversample tick, rounded, clamped to at least 1
//   - majority3() : 2-of-3 vote
package uart_pkg;

  localparam int unsigned OsRate   = 16;
  localparam logic [3:0]  VoteIdx0 = 4'd7;
  localparam logic [3:0]  VoteIdx1 = 4'd8;
  localparam logic [3:0]  VoteIdx2 = 4'd9;
  localparam logic [3:0]  LastIdx  = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // round(clk_freq / (16 * baud)); a zero result would stall the tick, so clamp to 1.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    int unsigned d;
    d = (clk_freq + 32'd8 * baud) / (OsRate * baud);
    return (d == 0) ? 32'd1 : d;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; counter restarts at 0
//   tick  : high for one cycle when the counter wraps (every Div cycles)
module uart_baud_tick #(
  parameter int unsigned Div = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CntW   = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling 8N1 UART receiver with 2-of-3 majority vote per bit.
//   i_Clk   : system clock
//   i_Rst   : asynchronous active-low reset
//   i_Rx    : serial line, asynchronous, idle high
//   o_fDone : one-cycle strobe, valid byte on o_Data
//   o_Data  : last good byte, held until the next good frame
//   o_fErr  : one-cycle strobe, stop bit sampled low
module uart_rx_os16 #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx,
  output logic       o_fDone,
  output logic [7:0] o_Data,
  output logic       o_fErr
);
  import uart_pkg::*;

  localparam int unsigned Div = calc_div(CLK_FREQ, BAUD);

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] samp_idx_q, samp_idx_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] vote_q, vote_d;  // samples taken at indices 7, 8, 9
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic tick, tick_clr, fall, vote_bit, vote_stop;

  uart_baud_tick #(
    .Div(Div)
  ) u_baud_tick (
    .clk  (i_Clk),
    .rst_n(i_Rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign vote_bit  = majority3(vote_q[0], vote_q[1], vote_q[2]);
  // Stop bit is decided on the index-9 tick itself, so the third sample is the live one.
  assign vote_stop = majority3(vote_q[0], vote_q[1], rx_sync_q);

  always_comb begin
    state_d    = state_q;
    samp_idx_d = samp_idx_q;
    bit_idx_d  = bit_idx_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tick_clr   = 1'b0;

    if ((state_q != StIdle) && tick) begin
      samp_idx_d = samp_idx_q + 4'd1;
      case (samp_idx_q)
        VoteIdx0: vote_d[0] = rx_sync_q;
        VoteIdx1: vote_d[1] = rx_sync_q;
        VoteIdx2: vote_d[2] = rx_sync_q;
        default:  ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d    = StStart;
          tick_clr   = 1'b1;
          samp_idx_d = '0;
        end
      end
      StStart: begin
        if (tick && (samp_idx_q == LastIdx)) begin
          if (!vote_bit) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;  // false start
          end
        end
      end
      StData: begin
        if (tick && (samp_idx_q == LastIdx)) begin
          shift_d   = {vote_bit, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        // Leave at mid stop bit to give slack for back-to-back frames.
        if (tick && (samp_idx_q == VoteIdx2)) begin
          state_d = StIdle;
          if (vote_stop) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      samp_idx_q <= '0;
      bit_idx_q  <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= i_Rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      samp_idx_q <= samp_idx_d;
      bit_idx_q  <= bit_idx_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_fDone = done_q;
  assign o_fErr  = err_q;
  assign o_Data  = data_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: self-checking bench for uart_rx_os16 at DIV=1 (16 clocks per bit).
// Frames are generated from the 8N1 line format; expected bytes, error counts and
// strobe latency come from that format, not from the receiver internals.
module tb_uart_rx_os16;
  import uart_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       done, err;
  logic [7:0] data;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [7:0]  done_data_q[$];
  int unsigned done_cyc_q[$];
  int unsigned err_cyc_q[$];
  int          both_cnt = 0;
  logic [7:0]  exp_data = 8'h00;

  uart_rx_os16 #(
    .CLK_FREQ(16_000_000),
    .BAUD    (1_000_000)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst_n),
    .i_Rx   (rx),
    .o_fDone(done),
    .o_Data (data),
    .o_fErr (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_data_q.push_back(data);
      done_cyc_q.push_back(cyc);
    end
    if (err) err_cyc_q.push_back(cyc);
    if (done && err) both_cnt++;
  end

  // Line level at cycle c of a 160-cycle 8N1 frame; noise flips sample 8 of each data bit.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input logic noise,
                                     input int c);
    int   bi;
    logic v;
    bi = c / 16;
    if (bi == 0) v = 1'b0;
    else if (bi <= 8) v = b[bi-1];
    else v = stop;
    if (noise && (bi >= 1) && (bi <= 8) && ((c % 16) == 8)) v = ~v;
    return v;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic noise,
                            output int unsigned start);
    start = cyc;
    for (int c = 0; c < 160; c++) begin
      rx = frame_bit(b, stop, noise, c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    done_data_q.delete();
    done_cyc_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
    if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
    n_cmp++;
    if (dut.state_q !== StIdle) begin
      n_bad++; $display("FAIL reset_state: got %0d want idle", dut.state_q);
    end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    int unsigned st;
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0, st);
    idle(20);
    exp_data = 8'hA5;
    n_cmp++;
    if (done_cyc_q.size() != 1) begin
      n_bad++; $display("FAIL single_count: got %0d strobes want 1", done_cyc_q.size());
    end else begin
      n_cmp++;
      if (done_data_q[0] !== 8'hA5) begin
        n_bad++; $display("FAIL single_data: got %h want a5", done_data_q[0]);
      end
      n_cmp++;
      if ((done_cyc_q[0] - st < 156) || (done_cyc_q[0] - st > 158)) begin
        n_bad++; $display("FAIL single_latency: got %0d want 157+-1", done_cyc_q[0] - st);
      end
    end
    n_cmp++;
    if (err_cyc_q.size() != 0) begin
      n_bad++; $display("FAIL single_err: got %0d errors want 0", err_cyc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  seq[8];
    int unsigned st;
    seq = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    clear_log();
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b1, 1'b0, st);
    idle(20);
    exp_data = 8'h77;
    n_cmp++;
    if (done_data_q.size() != 8) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 8", done_data_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      if (i < done_data_q.size()) begin
        n_cmp++;
        if (done_data_q[i] !== seq[i]) begin
          n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, done_data_q[i], seq[i]);
        end
      end
    end
    n_cmp++;
    if (err_cyc_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_err: got %0d want 0", err_cyc_q.size());
    end
  endtask

  task automatic test_glitch();
    int unsigned st;
    clear_log();
    rx = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rx = 1'b1;
    repeat (16) begin @(posedge clk); #1; end
    n_cmp++;
    if (dut.state_q !== StIdle) begin
      n_bad++; $display("FAIL glitch_state: got %0d want idle at cycle 20", dut.state_q);
    end
    idle(20);
    n_cmp++;
    if ((done_cyc_q.size() + err_cyc_q.size()) != 0) begin
      n_bad++;
      $display("FAIL glitch_strobe: got %0d strobes want 0", done_cyc_q.size() + err_cyc_q.size());
    end
    send_frame(8'h3C, 1'b1, 1'b0, st);
    idle(20);
    exp_data = 8'h3C;
    n_cmp++;
    if ((done_data_q.size() != 1) || (done_data_q[0] !== 8'h3C)) begin
      n_bad++; $display("FAIL glitch_next: got %0d strobes data %h want 1 x 3c",
                        done_data_q.size(), data);
    end
  endtask

  task automatic test_framing();
    int unsigned st;
    clear_log();
    send_frame(8'hFF, 1'b0, 1'b0, st);
    rx = 1'b0;
    repeat (640) begin @(posedge clk); #1; end
    n_cmp++;
    if (err_cyc_q.size() != 1) begin
      n_bad++; $display("FAIL frm_err_count: got %0d want 1", err_cyc_q.size());
    end else begin
      n_cmp++;
      if ((err_cyc_q[0] - st < 156) || (err_cyc_q[0] - st > 158)) begin
        n_bad++; $display("FAIL frm_err_latency: got %0d want 157+-1", err_cyc_q[0] - st);
      end
    end
    n_cmp++;
    if (done_cyc_q.size() != 0) begin
      n_bad++; $display("FAIL frm_done: got %0d want 0", done_cyc_q.size());
    end
    n_cmp++;
    if (data !== exp_data) begin
      n_bad++; $display("FAIL frm_data_hold: got %h want %h", data, exp_data);
    end
    idle(32);
    send_frame(8'h5A, 1'b1, 1'b0, st);
    idle(20);
    exp_data = 8'h5A;
    n_cmp++;
    if ((done_data_q.size() != 1) || (data !== 8'h5A) || (err_cyc_q.size() != 1)) begin
      n_bad++; $display("FAIL frm_recover: got %0d strobes data %h errs %0d want 1 5a 1",
                        done_data_q.size(), data, err_cyc_q.size());
    end
  endtask

  task automatic test_noise();
    int unsigned st;
    clear_log();
    send_frame(8'h96, 1'b1, 1'b1, st);
    idle(20);
    exp_data = 8'h96;
    n_cmp++;
    if ((done_data_q.size() != 1) || (data !== 8'h96) || (err_cyc_q.size() != 0)) begin
      n_bad++; $display("FAIL noise: got %0d strobes data %h errs %0d want 1 96 0",
                        done_data_q.size(), data, err_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int unsigned st;
    clear_log();
    for (int c = 0; c < 160; c++) begin
      rx = frame_bit(8'h81, 1'b1, 1'b0, c);
      if (c == 56) begin
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ((data !== 8'h00) || (done !== 1'b0) || (err !== 1'b0)) begin
          n_bad++; $display("FAIL midrst_outputs: got data %h done %b err %b want 00 0 0",
                            data, done, err);
        end
      end
      @(posedge clk);
      #1;
    end
    exp_data = 8'h00;
    idle(16);
    rst_n = 1'b1;
    idle(40);
    n_cmp++;
    if ((done_cyc_q.size() + err_cyc_q.size()) != 0) begin
      n_bad++; $display("FAIL midrst_partial: got %0d strobes want 0",
                        done_cyc_q.size() + err_cyc_q.size());
    end
    send_frame(8'h42, 1'b1, 1'b0, st);
    idle(20);
    exp_data = 8'h42;
    n_cmp++;
    if ((done_data_q.size() != 1) || (data !== 8'h42)) begin
      n_bad++; $display("FAIL midrst_next: got %0d strobes data %h want 1 42",
                        done_data_q.size(), data);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_q[$];
    int          exp_err;
    int unsigned st;
    logic [7:0]  b;
    logic        bad, noise;
    clear_log();
    both_cnt = 0;
    exp_err  = 0;
    for (int i = 0; i < 24; i++) begin
      b     = 8'($urandom);
      bad   = ($urandom_range(4) == 0);
      noise = 1'($urandom_range(1));
      send_frame(b, ~bad, noise, st);
      if (bad) begin
        exp_err++;
        idle($urandom_range(30, 2));  // line must rise before the next start edge
      end else begin
        exp_q.push_back(b);
        exp_data = b;
        idle($urandom_range(30, 0));
      end
    end
    idle(20);
    n_cmp++;
    if (done_data_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rand_count: got %0d want %0d", done_data_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < done_data_q.size()) begin
        n_cmp++;
        if (done_data_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, done_data_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (err_cyc_q.size() != exp_err) begin
      n_bad++; $display("FAIL rand_err: got %0d want %0d", err_cyc_q.size(), exp_err);
    end
    n_cmp++;
    if (data !== exp_data) begin
      n_bad++; $display("FAIL rand_hold: got %h want %h", data, exp_data);
    end
    n_cmp++;
    if (both_cnt != 0) begin
      n_bad++; $display("FAIL rand_both: got %0d coincident strobes want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_noise();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
